// File: rtl/ngc_capture_if.sv
// ---------------------------------------------------------------------------
// ngc_capture_if
// Result handshake between the input-capture block and its consumer
// (register bank, FIFO, ...).
//
//   capture_value : measured cycle count, WIDTH bits      (master -> slave)
//   capture_valid : capture_value holds an unconsumed result (master -> slave)
//   capture_ready : consumer accepts the result this cycle  (slave -> master)
//
// A transfer happens on a clock edge where capture_valid and capture_ready
// are both high.
// ---------------------------------------------------------------------------
interface ngc_capture_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] capture_value;
    logic             capture_valid;
    logic             capture_ready;

    modport master (
        output capture_value,
        output capture_valid,
        input  capture_ready
    );

    modport slave (
        input  capture_value,
        input  capture_valid,
        output capture_ready
    );
endinterface

// File: rtl/ngc_capture.sv
// ---------------------------------------------------------------------------
// ngc_capture
// Input-capture / period-measurement block. sig_in is synchronized, its
// edges are detected, and the number of clocks between a start edge and a
// stop edge is counted and handed to a consumer through a one-entry slot.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   enb            : 1 = measure, 0 = return to IDLE (pending result kept)
//   mode           : 0 = period (rise->rise), 1 = high width (rise->fall)
//   one_shot       : 1 = stop after the first capture until enb drops
//   sig_in         : asynchronous input under measurement
//   timeout_value  : abort a measurement when the count reaches it; 0 = off
//   cap            : result handshake (capture_value/valid/ready)
//   overrun        : sticky, a result was dropped because the slot was full
//   timeout        : one-cycle pulse when a measurement is aborted
//   busy           : high while a measurement is in progress
// ---------------------------------------------------------------------------
module ngc_capture #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             mode,
    input  logic             one_shot,
    input  logic             sig_in,
    input  logic [WIDTH-1:0] timeout_value,
    ngc_capture_if.master    cap,
    output logic             overrun,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s_prev;
    logic [WIDTH-1:0]       cnt;
    logic                   mode_q;

    logic s;
    logic rise;
    logic fall;
    logic stop_edge;
    logic tmo_hit;
    logic result;

    // Count up, holding at all-ones so an over-long interval reads as max.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    // Edge detect on the synchronized level. The history flop runs in every
    // state, so a level already high at enable never looks like a rise.
    assign s    = sync_p[SYNC_STAGES-1];
    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

    assign stop_edge = (state == MEASURE) && (mode_q ? fall : rise);
    // A stop edge in the same cycle takes precedence over the timeout.
    assign tmo_hit   = (state == MEASURE) && !stop_edge &&
                       (timeout_value != '0) && (cnt == timeout_value);
    assign result    = enb && stop_edge;
    assign busy      = (state == MEASURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            mode_q            <= 1'b0;
            sync_p            <= '0;
            s_prev            <= 1'b0;
            cap.capture_value <= '0;
            cap.capture_valid <= 1'b0;
            overrun           <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            // ---- stage: synchronizer and edge history ----
            sync_p  <= {sync_p[SYNC_STAGES-2:0], sig_in};
            s_prev  <= s;
            timeout <= 1'b0;

            // ---- stage: output slot ----
            // The slot is free when empty or draining this same cycle.
            if (result) begin
                if (!cap.capture_valid || cap.capture_ready) begin
                    cap.capture_value <= cnt;
                    cap.capture_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (cap.capture_valid && cap.capture_ready) begin
                cap.capture_valid <= 1'b0;
            end

            // ---- stage: measurement control ----
            if (!enb) begin
                state   <= IDLE;
                cnt     <= '0;
                overrun <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (rise) begin
                            state  <= MEASURE;
                            cnt    <= WIDTH'(1);
                            mode_q <= mode;
                        end
                    end
                    MEASURE: begin
                        if (stop_edge) begin
                            if (one_shot) begin
                                state <= DONE;
                                cnt   <= '0;
                            end else if (!mode_q) begin
                                // The stop rise is also the next start rise.
                                cnt <= WIDTH'(1);
                            end else begin
                                state <= ARMED;
                                cnt   <= '0;
                            end
                        end else if (tmo_hit) begin
                            timeout <= 1'b1;
                            cnt     <= '0;
                            state   <= ARMED;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    DONE: state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ngc_capture.sv
// ---------------------------------------------------------------------------
// tb_ngc_capture
// Self-checking bench for ngc_capture. sig_in is driven as square waves with
// randomized high/low times; expected results are derived from the wave
// parameters (edge-to-edge distances) and compared against the transfers
// collected by a handshake monitor.
// ---------------------------------------------------------------------------
module tb_ngc_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        mode;
    logic        one_shot;
    logic        sig_in;
    logic        enb4;
    logic [15:0] timeout_value;
    logic        overrun, timeout, busy;
    logic        overrun4, timeout4, busy4;

    int n_checks = 0;
    int n_pass   = 0;

    ngc_capture_if #(.WIDTH(16)) cif ();
    ngc_capture_if #(.WIDTH(4))  cif4 ();

    ngc_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .enb(enb), .mode(mode), .one_shot(one_shot),
        .sig_in(sig_in), .timeout_value(timeout_value), .cap(cif),
        .overrun(overrun), .timeout(timeout), .busy(busy)
    );

    ngc_capture #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .enb(enb4), .mode(1'b0), .one_shot(1'b0),
        .sig_in(sig_in), .timeout_value(4'd0), .cap(cif4),
        .overrun(overrun4), .timeout(timeout4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Handshake / event monitor
    int   cap_vals[$];
    int   cap_times[$];
    int   cap4_vals[$];
    int   cyc           = 0;
    int   to_pulses     = 0;
    int   to_cyc        = 0;
    int   busy_rise_cyc = 0;
    int   busy_low      = 0;
    logic busy_d        = 1'b0;
    logic watch_busy    = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        busy_d <= busy;
        if (!rst) begin
            if (cif.capture_valid && cif.capture_ready) begin
                cap_vals.push_back(int'(cif.capture_value));
                cap_times.push_back(cyc);
            end
            if (cif4.capture_valid && cif4.capture_ready)
                cap4_vals.push_back(int'(cif4.capture_value));
            if (timeout) begin
                to_pulses <= to_pulses + 1;
                to_cyc    <= cyc;
            end
            if (busy && !busy_d) busy_rise_cyc <= cyc;
            if (watch_busy && !busy) busy_low <= busy_low + 1;
        end
    end

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic go_idle();
        enb = 1'b0; sig_in = 1'b0; cif.capture_ready = 1'b1;
        one_shot = 1'b0; mode = 1'b0; timeout_value = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enb = 1'b0; enb4 = 1'b0; mode = 1'b0; one_shot = 1'b0;
        sig_in = 1'b0; timeout_value = '0;
        cif.capture_ready = 1'b0; cif4.capture_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (cif.capture_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cif.capture_valid); else n_pass++;
        n_checks++; if (cif.capture_value !== 16'd0) $display("FAIL reset_value: got %0d expected 0", cif.capture_value); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_period();
        int p, hi, k, base, bl, n;
        p = $urandom_range(4, 20); hi = p / 2; k = $urandom_range(3, 6);
        mode = 1'b0; one_shot = 1'b0; timeout_value = '0;
        cif.capture_ready = 1'b1; sig_in = 1'b0; enb = 1'b1;
        repeat (3) @(negedge clk);
        base = cap_vals.size();
        wave(hi, p - hi, 1);
        bl = busy_low; watch_busy = 1'b1;
        wave(hi, p - hi, k);
        repeat (6) @(negedge clk);
        watch_busy = 1'b0;
        n = cap_vals.size() - base;
        n_checks++; if (n !== k) $display("FAIL period_count: got %0d expected %0d", n, k); else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_checks++; if (cap_vals[base+i] !== p) $display("FAIL period_value[%0d]: got %0d expected %0d", i, cap_vals[base+i], p); else n_pass++;
        end
        for (int i = 1; i < n; i++) begin
            n_checks++; if (cap_times[base+i] - cap_times[base+i-1] !== p) $display("FAIL period_gap[%0d]: got %0d expected %0d", i, cap_times[base+i] - cap_times[base+i-1], p); else n_pass++;
        end
        n_checks++; if (busy_low - bl !== 0) $display("FAIL period_busy_low: got %0d cycles expected 0", busy_low - bl); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL period_busy: got %b expected 1", busy); else n_pass++;
        go_idle();
    endtask

    task automatic test_width();
        int h, l, k, base, n;
        h = $urandom_range(2, 6); l = $urandom_range(3, 10); k = $urandom_range(3, 5);
        mode = 1'b1; one_shot = 1'b0; timeout_value = '0;
        cif.capture_ready = 1'b1; sig_in = 1'b0; enb = 1'b1;
        repeat (3) @(negedge clk);
        base = cap_vals.size();
        wave(h, l, k);
        repeat (6) @(negedge clk);
        n = cap_vals.size() - base;
        n_checks++; if (n !== k) $display("FAIL width_count: got %0d expected %0d", n, k); else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_checks++; if (cap_vals[base+i] !== h) $display("FAIL width_value[%0d]: got %0d expected %0d", i, cap_vals[base+i], h); else n_pass++;
        end
        for (int i = 1; i < n; i++) begin
            n_checks++; if (cap_times[base+i] - cap_times[base+i-1] !== h + l) $display("FAIL width_gap[%0d]: got %0d expected %0d", i, cap_times[base+i] - cap_times[base+i-1], h + l); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL width_busy_low_phase: got %b expected 0", busy); else n_pass++;
        go_idle();
    endtask

    task automatic test_backpressure();
        int p, hi, base;
        p = $urandom_range(6, 12); hi = p / 2;
        mode = 1'b0; one_shot = 1'b0; timeout_value = '0;
        cif.capture_ready = 1'b0; sig_in = 1'b0; enb = 1'b1;
        repeat (3) @(negedge clk);
        wave(hi, p - hi, 2);
        n_checks++; if (cif.capture_valid !== 1'b1) $display("FAIL bp_valid: got %b expected 1", cif.capture_valid); else n_pass++;
        n_checks++; if (cif.capture_value !== 16'(p)) $display("FAIL bp_first_value: got %0d expected %0d", cif.capture_value, p); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL bp_overrun_early: got %b expected 0", overrun); else n_pass++;
        wave(hi, p - hi, 1);
        n_checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun_set: got %b expected 1", overrun); else n_pass++;
        wave(hi, p - hi, 1);
        n_checks++; if (cif.capture_value !== 16'(p)) $display("FAIL bp_value_held: got %0d expected %0d", cif.capture_value, p); else n_pass++;
        base = cap_vals.size();
        cif.capture_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (cif.capture_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b expected 0", cif.capture_valid); else n_pass++;
        n_checks++; if (cap_vals.size() - base !== 1) $display("FAIL bp_transfers: got %0d expected 1", cap_vals.size() - base); else n_pass++;
        if (cap_vals.size() > base) begin
            n_checks++; if (cap_vals[base] !== p) $display("FAIL bp_transfer_value: got %0d expected %0d", cap_vals[base], p); else n_pass++;
        end
        n_checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun_sticky: got %b expected 1", overrun); else n_pass++;
        enb = 1'b0;
        @(negedge clk);
        n_checks++; if (overrun !== 1'b0) $display("FAIL bp_overrun_clear: got %b expected 0", overrun); else n_pass++;
        go_idle();
    endtask

    task automatic test_timeout();
        int t, base, tp;
        t = $urandom_range(10, 30);
        timeout_value = 16'(t); mode = 1'b0; one_shot = 1'b0;
        cif.capture_ready = 1'b1; sig_in = 1'b0; enb = 1'b1;
        repeat (3) @(negedge clk);
        base = cap_vals.size(); tp = to_pulses;
        sig_in = 1'b1;
        repeat (t + 10) @(negedge clk);
        n_checks++; if (to_pulses - tp !== 1) $display("FAIL timeout_pulses: got %0d expected 1", to_pulses - tp); else n_pass++;
        n_checks++; if (to_cyc - busy_rise_cyc !== t) $display("FAIL timeout_delay: got %0d expected %0d", to_cyc - busy_rise_cyc, t); else n_pass++;
        n_checks++; if (cap_vals.size() - base !== 0) $display("FAIL timeout_no_capture: got %0d expected 0", cap_vals.size() - base); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL timeout_armed: got busy %b expected 0", busy); else n_pass++;
        // Re-armed: a stop edge landing exactly on the timeout count wins.
        sig_in = 1'b0; timeout_value = 16'd5;
        repeat (3) @(negedge clk);
        base = cap_vals.size(); tp = to_pulses;
        wave(2, 3, 2);
        n_checks++; if (cap_vals.size() - base !== 1) $display("FAIL timeout_tie_count: got %0d expected 1", cap_vals.size() - base); else n_pass++;
        if (cap_vals.size() > base) begin
            n_checks++; if (cap_vals[base] !== 5) $display("FAIL timeout_tie_value: got %0d expected 5", cap_vals[base]); else n_pass++;
        end
        n_checks++; if (to_pulses - tp !== 0) $display("FAIL timeout_tie_pulse: got %0d expected 0", to_pulses - tp); else n_pass++;
        go_idle();
    endtask

    task automatic test_saturation();
        int base, n;
        enb = 1'b0; sig_in = 1'b0; enb4 = 1'b1;
        repeat (3) @(negedge clk);
        base = cap4_vals.size();
        wave(12, 13, 3);
        n = cap4_vals.size() - base;
        n_checks++; if (n !== 2) $display("FAIL sat_count: got %0d expected 2", n); else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_checks++; if (cap4_vals[base+i] !== 15) $display("FAIL sat_value[%0d]: got %0d expected 15", i, cap4_vals[base+i]); else n_pass++;
        end
        enb4 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_one_shot();
        int p, hi, base;
        p = $urandom_range(4, 12); hi = p / 2;
        mode = 1'b0; one_shot = 1'b1; timeout_value = '0;
        cif.capture_ready = 1'b1; sig_in = 1'b0; enb = 1'b1;
        repeat (3) @(negedge clk);
        base = cap_vals.size();
        wave(hi, p - hi, 4);
        repeat (4) @(negedge clk);
        n_checks++; if (cap_vals.size() - base !== 1) $display("FAIL oneshot_count: got %0d expected 1", cap_vals.size() - base); else n_pass++;
        if (cap_vals.size() > base) begin
            n_checks++; if (cap_vals[base] !== p) $display("FAIL oneshot_value: got %0d expected %0d", cap_vals[base], p); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL oneshot_busy: got %b expected 0", busy); else n_pass++;
        enb = 1'b0;
        repeat (2) @(negedge clk);
        enb = 1'b1;
        repeat (3) @(negedge clk);
        base = cap_vals.size();
        wave(hi, p - hi, 3);
        repeat (4) @(negedge clk);
        n_checks++; if (cap_vals.size() - base !== 1) $display("FAIL oneshot_rearm_count: got %0d expected 1", cap_vals.size() - base); else n_pass++;
        if (cap_vals.size() > base) begin
            n_checks++; if (cap_vals[base] !== p) $display("FAIL oneshot_rearm_value: got %0d expected %0d", cap_vals[base], p); else n_pass++;
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        int p, hi, base;
        p = $urandom_range(5, 12); hi = p / 2;
        mode = 1'b0; one_shot = 1'b0; timeout_value = '0;
        cif.capture_ready = 1'b0; sig_in = 1'b0; enb = 1'b1;
        repeat (3) @(negedge clk);
        wave(hi, p - hi, 2);
        n_checks++; if (busy !== 1'b1) $display("FAIL rmid_pre_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (cif.capture_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b expected 1", cif.capture_valid); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (cif.capture_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", cif.capture_valid); else n_pass++;
        n_checks++; if (cif.capture_value !== 16'd0) $display("FAIL rmid_value: got %0d expected 0", cif.capture_value); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL rmid_overrun: got %b expected 0", overrun); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL rmid_timeout: got %b expected 0", timeout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else n_pass++;
        cif.capture_ready = 1'b1;
        repeat (3) @(negedge clk);
        base = cap_vals.size();
        wave(hi, p - hi, 2);
        repeat (4) @(negedge clk);
        n_checks++; if (cap_vals.size() - base !== 1) $display("FAIL rmid_fresh_count: got %0d expected 1", cap_vals.size() - base); else n_pass++;
        if (cap_vals.size() > base) begin
            n_checks++; if (cap_vals[base] !== p) $display("FAIL rmid_fresh_value: got %0d expected %0d", cap_vals[base], p); else n_pass++;
        end
        go_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_period();
        test_width();
        test_backpressure();
        test_timeout();
        test_saturation();
        test_one_shot();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ngc_capture.md
Name: ngc_capture

Overview:
Input-capture / period-measurement block, the inverse of the team's programmable counter: the counter turns programmed values into timed events, and this block turns external events into measured values. It synchronizes an asynchronous input and counts clock cycles between selected edges. Each measured value is delivered over a valid/ready handshake to a consumer such as a register bank or FIFO. It is used to measure pulse widths and periods from external sensors and peer timers.

Parameters:
WIDTH, 16, width of the measured count, timeout_value and capture_value
SYNC_STAGES, 2, number of synchronizer flops on sig_in (minimum 2)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
enb  input  1  1 = measurement enabled; 0 = go idle
mode  input  1  0 = period (rise to rise); 1 = high-pulse width (rise to fall)
one_shot  input  1  1 = stop after first capture until enb is deasserted
sig_in  input  1  asynchronous input being measured
timeout_value  input  WIDTH  abort a measurement when count reaches this value; 0 = disabled
capture_value  output  WIDTH  measured cycle count
capture_valid  output  1  capture_value holds an unconsumed result
capture_ready  input  1  consumer accepts result when high together with capture_valid
overrun  output  1  sticky: a result was dropped because the output slot was full
timeout  output  1  one-cycle pulse when a measurement is aborted by timeout
busy  output  1  high while in MEASURE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; cnt, capture_value, capture_valid, overrun, timeout all 0; synchronizer and edge-history flops 0. rst has priority over every other input.
- Synchronizer: SYNC_STAGES flops, then a history flop s_prev. rise = s & ~s_prev; fall = ~s & s_prev. The history flop updates every cycle in every state, so a sig_in already high at enable does not produce a rise.
- mode is latched into mode_q on the start edge; changing mode mid-measurement has no effect until the next start.
- States:
  - IDLE: enb=1 -> ARMED.
  - ARMED: rise -> MEASURE, cnt<=1, mode_q<=mode.
  - MEASURE: cnt<=cnt+1 each cycle, saturating at all-ones. The stop edge is rise if mode_q=0, fall if mode_q=1.
  - On the stop edge, cnt is captured, so an edge-to-edge distance of N clocks yields capture_value=N. Saturated measurements report all-ones.
  - After the stop edge: if one_shot=1 -> DONE. Otherwise mode_q=0 -> stay in MEASURE with cnt<=1 (back-to-back periods, no lost edge); mode_q=1 -> ARMED.
  - Timeout: if timeout_value!=0 and cnt==timeout_value with no stop edge that cycle, timeout pulses 1 for one cycle, there is no capture, cnt<=0 and state -> ARMED. A stop edge in the same cycle wins over timeout.
  - DONE: holds until enb=0.
- enb=0 in any state: state -> IDLE next cycle and cnt<=0. A pending capture_valid/capture_value is kept and can still be consumed. overrun clears when enb=0.
- Output slot (one entry):
  - A result loads when the slot is free, meaning capture_valid=0 or capture_ready=1 in the same cycle. Transfer and new load in one cycle leaves capture_valid=1 with the new value.
  - If the slot is full and not draining, the new result is dropped, the old value is held and overrun<=1 (sticky until rst or enb=0).
  - capture_value is stable while capture_valid=1 and capture_ready=0.
  - Handshake transfer occurs on a posedge with capture_valid and capture_ready both high; capture_valid drops next cycle unless a new result loads.
- busy=1 exactly when state=MEASURE.
- Latency: an edge on sig_in reaches rise/fall SYNC_STAGES+1 clocks later; capture_valid rises one clock after the stop-edge detection cycle.

Test Plan:
- Period: mode=0, enb=1, capture_ready=1, sig_in square wave with period 10 clk -> capture_valid pulses every 10 cycles with capture_value=10; no gap after the first capture; busy stays 1.
- Width: mode=1, sig_in high 3 clk / low 7 clk -> capture_value=3 once per 10 cycles; busy=0 during the low phase.
- Backpressure: mode=0, period 8, capture_ready=0 for 3 periods -> first value 8 held stable, overrun=1 after the second stop edge; then ready=1 -> one transfer, capture_valid=0 next cycle; enb=0 clears overrun.
- Timeout/saturation:
  - timeout_value=20, a single rise and no further edge -> timeout pulse when cnt=20, no capture_valid, state back to ARMED.
  - WIDTH=4, timeout_value=0, period 25 -> capture_value=15.
- One-shot and enable: one_shot=1, period 6 -> exactly one capture of 6, busy=0, no further captures; toggle enb 0->1 -> a new capture occurs.
- Reset mid-measure: rst=1 for one cycle during MEASURE with capture_valid=1 -> next cycle all outputs 0, state IDLE; a following rise with enb=1 starts a fresh measurement.
